// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one 16-bit memory bus between CPU (port 0) and DMA (port 1).
// Optional bus timeout enabled by defining MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int WAIT_STATES    = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    output logic [15:0] o_cpu_rdata,
    output logic        o_cpu_ack,
    input  logic        i_dma_req,
    input  logic        i_dma_we,
    input  logic [15:0] i_dma_addr,
    input  logic [15:0] i_dma_wdata,
    output logic [15:0] o_dma_rdata,
    output logic        o_dma_ack,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ready,
    output logic        o_busy,
    output logic        o_err
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t      r_state;
    logic        r_ptr;
    logic        r_owner;
    logic [3:0]  r_cnt;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_dma_rdata;
    logic        r_cpu_ack;
    logic        r_dma_ack;
    logic        r_busy;

    logic        w_req;
    logic        w_grant;
    logic        w_we;
    logic [15:0] w_addr;
    logic [15:0] w_wdata;
    logic        w_tout;
    logic        w_fin;
    logic [15:0] w_fin_data;

    // Grant selection: a lone requester wins, a tie goes to the priority pointer
    always_comb begin
        w_req      = i_cpu_req | i_dma_req;
        w_grant    = (i_cpu_req & i_dma_req) ? r_ptr : i_dma_req;
        w_we       = w_grant ? i_dma_we    : i_cpu_we;
        w_addr     = w_grant ? i_dma_addr  : i_cpu_addr;
        w_wdata    = w_grant ? i_dma_wdata : i_cpu_wdata;
        w_fin      = (r_cnt == 4'd0) && (i_mem_ready || w_tout);
        w_fin_data = w_tout ? 16'hFFFF : (r_mem_wr ? 16'h0000 : i_mem_rdata);
    end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    logic [7:0] r_to;
    logic       r_err;

    assign w_tout = (r_cnt == 4'd0) && !i_mem_ready && (r_to == 8'(TIMEOUT_CYCLES - 1));
    assign o_err  = r_err;

    // Count consecutive not-ready cycles once wait states are spent; flag the abort in the DONE cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to  <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_to  <= (r_state == S_ACCESS && r_cnt == 4'd0 && !i_mem_ready) ? r_to + 8'd1 : 8'd0;
            r_err <= (r_state == S_ACCESS) && w_tout;
        end
    end
`else
    logic w_unused_timeout;

    assign w_tout           = 1'b0;
    assign o_err            = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Access sequencer: grant and latch in IDLE, strobe through ACCESS, acknowledge in DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_cnt       <= 4'd0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_cpu_rdata <= 16'h0000;
            r_dma_rdata <= 16'h0000;
            r_cpu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state     <= S_ACCESS;
                        r_owner     <= w_grant;
                        r_ptr       <= !w_grant;
                        r_cnt       <= 4'(WAIT_STATES);
                        r_mem_rd    <= !w_we;
                        r_mem_wr    <= w_we;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_we ? w_wdata : 16'h0000;
                        r_busy      <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (w_fin) begin
                        r_state     <= S_DONE;
                        r_mem_rd    <= 1'b0;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= 16'h0000;
                        r_mem_wdata <= 16'h0000;
                        if (r_owner) begin
                            r_dma_rdata <= w_fin_data;
                            r_dma_ack   <= 1'b1;
                        end else begin
                            r_cpu_rdata <= w_fin_data;
                            r_cpu_ack   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_cpu_ack <= 1'b0;
                    r_dma_ack <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cpu_rdata = r_cpu_rdata;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_dma_rdata = r_dma_rdata;
    assign o_dma_ack   = r_dma_ack;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit external memory bus between two requesters: port 0 (CPU core load/store/fetch) and port 1 (DMA/boot loader).
- Arbitrates round-robin, latches the winning request and sequences the memory strobes with programmable wait states plus a ready handshake.
- Returns read data and a one-cycle acknowledge to the owner.
- Sits between the core's bus pins and the board memory/IO decoder.

Parameters:
- WAIT_STATES, 1, extra strobe cycles before i_mem_ready is sampled (0..15).
- TIMEOUT_CYCLES, 15, maximum cycles to wait for i_mem_ready after the wait states (used only with the optional feature, 1..255).

Ports:
- i_clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_cpu_req  in  1  port 0 access request, held until o_cpu_ack
- i_cpu_we  in  1  port 0: 1 = write, 0 = read
- i_cpu_addr  in  16  port 0 address
- i_cpu_wdata  in  16  port 0 write data
- o_cpu_rdata  out  16  port 0 read data, valid while o_cpu_ack=1
- o_cpu_ack  out  1  port 0 completion pulse
- i_dma_req / i_dma_we / i_dma_addr / i_dma_wdata  in  1/1/16/16  port 1, same rules as port 0
- o_dma_rdata  out  16  port 1 read data
- o_dma_ack  out  1  port 1 completion pulse
- o_mem_rd  out  1  memory read strobe
- o_mem_wr  out  1  memory write strobe
- o_mem_addr  out  16  memory address
- o_mem_wdata  out  16  memory write data (0x0000 when not writing)
- i_mem_rdata  in  16  memory read data
- i_mem_ready  in  1  memory completion; tie high for fixed-latency memory
- o_busy  out  1  1 when state is not IDLE
- o_err  out  1  timeout pulse (constant 0 without the optional feature)

Behaviour:
- Reset (async assert, sync release) forces:
  - state=IDLE, priority pointer=port 0.
  - All strobes, acks, o_busy and o_err = 0.
  - o_mem_addr, o_mem_wdata, o_cpu_rdata and o_dma_rdata = 0x0000.
- Reset mid-access aborts the access immediately; no ack is issued.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - Exactly one request: grant it.
    - Both requests: grant the port named by the priority pointer.
    - On grant: latch owner, we, addr and wdata; load wait counter with WAIT_STATES; go to ACCESS.
    - Pointer then points to the non-granted port. With only one requester, the pointer still moves away from the granted port.
  - ACCESS:
    - o_mem_addr = latched addr.
    - o_mem_rd = !we, o_mem_wr = we; o_mem_wdata = latched wdata on writes.
    - Counter decrements each cycle while nonzero.
    - When counter==0 and i_mem_ready=1: register i_mem_rdata (reads; writes register 0x0000) into the owner's rdata; go to DONE.
    - When counter==0 and i_mem_ready=0: stay in ACCESS, strobes held.
  - DONE:
    - Strobes deasserted; owner's ack=1 for exactly this cycle; owner's rdata valid.
    - Always returns to IDLE next cycle.
- Rdata outputs hold their last value until the next completion on that port.
- Timing: request sampled in IDLE at cycle 0 → strobes cycles 1..1+WAIT_STATES (longer if not ready) → ack at cycle 2+WAIT_STATES.
- Minimum period between back-to-back accesses = WAIT_STATES+3 cycles.
- Requesters drop req on the edge after ack. A req still high in the IDLE cycle after DONE is a new request.
- Request inputs are ignored outside IDLE; inputs need to be stable only while req=1 in IDLE.
- Both ports continuously requesting alternate strictly: 0,1,0,1…
- o_mem_rd and o_mem_wr are never both 1.

Optional Feature:
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A timeout counter starts when the wait counter reaches 0.
  - If i_mem_ready stays 0 for TIMEOUT_CYCLES consecutive cycles, the access aborts to DONE.
  - The owner's rdata becomes 0xFFFF, and o_err=1 coincident with that ack.
- Undefined:
  - ACCESS waits for i_mem_ready indefinitely.
  - o_err is tied to 0 and the timeout counter is not synthesized.

Test Plan:
- Reset with all requests active → all outputs 0; first grant goes to port 0 after reset release.
- WAIT_STATES=1, CPU read addr 0x1234, memory returns 0xBEEF with ready high → o_mem_rd high for cycles 1–2, o_cpu_ack at cycle 3, o_cpu_rdata=0xBEEF, o_dma_ack never asserted.
- CPU and DMA request together, both writes (CPU 0x0010←0xAAAA, DMA 0x0020←0x5555) → CPU serviced first, then DMA; o_mem_wr address sequence 0x0010 then 0x0020; acks 4 cycles apart (WAIT_STATES=1).
- Both ports held requesting for 6 accesses → grant order 0,1,0,1,0,1; o_mem_rd and o_mem_wr never both high.
- i_mem_ready held low for 5 cycles during a DMA read → strobes held, ack 5 cycles late, data captured on the ready cycle.
- MEM_BUS_ARBITER_TIMEOUT_EN with TIMEOUT_CYCLES=4 and ready stuck low → ack after 4 timeout cycles; o_err=1 and rdata=0xFFFF in the same cycle; next request is served normally. Additionally: i_rst_n pulsed low mid-ACCESS → strobes drop asynchronously and no ack is issued.
